// File: rtl/alu_sequenciador.sv
// ---------------------------------------------------------------------------
// alu_sequenciador
// Execute-stage sequencer wrapped around the combinational 8-bit ALU.
// It accepts one instruction per valid/ready handshake, fetches its operands
// from an internal register file, drives the ALU inputs, and captures the
// ALU result and flags. It then writes the result back and updates the
// architectural flags register.
// Sequence: IDLE -> FETCH -> EXEC -> WRITE -> IDLE (one instruction per 4 cycles).
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   instr_valid/ready     decode handshake
//   instr_op/rd/rs/rt     operation code, destination and source registers
//   instr_imm_en/imm      select immediate as operand B, immediate value
//   alu_a/b/operacao      registered ALU inputs
//   alu_resultado/flags   ALU outputs (flags = {N,Z,C,P,I,D,V,-})
//   done/done_rd/done_data  one-cycle retirement pulse with destination/result
//   flags_reg             architectural flags register
//   dbg_addr/dbg_data     combinational register-file read port
// ---------------------------------------------------------------------------
module alu_sequenciador #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [REG_AW-1:0] instr_rt,
  input  logic              instr_imm_en,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_operacao,
  input  logic [DATA_W-1:0] alu_resultado,
  input  logic [DATA_W-1:0] alu_flags,
  output logic              done,
  output logic [REG_AW-1:0] done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic [DATA_W-1:0] flags_reg,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched instruction fields
  logic [3:0]        op_p0;
  logic [REG_AW-1:0] rd_p0;
  logic [REG_AW-1:0] rs_p0;
  logic [REG_AW-1:0] rt_p0;
  logic              imm_en_p0;
  logic [DATA_W-1:0] imm_p0;

  // Captured ALU outputs
  logic [DATA_W-1:0] res_p2;
  logic [DATA_W-1:0] flg_p2;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic is_nop;

  // R0 is hard-wired to zero on every read path.
  function automatic logic [DATA_W-1:0] read_reg(input logic [REG_AW-1:0] idx);
    if (idx == '0) return '0;
    return regs[idx];
  endfunction

  // Carry is only architecturally meaningful for add (0000) and sub (0001).
  function automatic logic [DATA_W-1:0] mask_flags(input logic [3:0]        op,
                                                   input logic [DATA_W-1:0] f);
    logic [DATA_W-1:0] m;
    m = f;
    if (op != 4'd0 && op != 4'd1) m[5] = 1'b0;
    return m;
  endfunction

  assign is_nop      = (op_p0[3:1] == 3'b111);
  assign instr_ready = (state == IDLE) && !reset;

  always_comb begin
    dbg_data = read_reg(dbg_addr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: instruction capture; p2: ALU output capture
  always_ff @(posedge clk) begin
    if (state == IDLE && instr_valid && instr_ready) begin
      op_p0     <= instr_op;
      rd_p0     <= instr_rd;
      rs_p0     <= instr_rs;
      rt_p0     <= instr_rt;
      imm_en_p0 <= instr_imm_en;
      imm_p0    <= instr_imm;
    end
    if (state == EXEC) begin
      res_p2 <= alu_resultado;
      flg_p2 <= alu_flags;
    end
  end

  // p1: operand fetch into ALU inputs; p3: write-back and retirement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      flags_reg    <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_operacao <= '0;
      done         <= 1'b0;
      done_rd      <= '0;
      done_data    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        FETCH: begin
          alu_a        <= read_reg(rs_p0);
          alu_b        <= imm_en_p0 ? imm_p0 : read_reg(rt_p0);
          alu_operacao <= op_p0;
        end
        WRITE: begin
          done      <= 1'b1;
          done_rd   <= rd_p0;
          done_data <= is_nop ? '0 : res_p2;
          if (!is_nop) begin
            if (rd_p0 != '0) regs[rd_p0] <= res_p2;
            flags_reg <= mask_flags(op_p0, flg_p2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequenciador.sv
// ---------------------------------------------------------------------------
// tb_alu_sequenciador
// Directed self-checking bench for alu_sequenciador. A small ALU stand-in
// supplies alu_resultado/alu_flags: add, sub, and, divide (x/0 = 0xFF),
// xor for everything else. Its flags are N, Z, raw carry of a+b (borrow for
// sub), P = positive non-zero, V = signed add overflow.
// ---------------------------------------------------------------------------
module tb_alu_sequenciador;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [2:0] instr_rd, instr_rs, instr_rt;
  logic       instr_imm_en;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_operacao;
  logic [7:0] alu_resultado, alu_flags;
  logic       done;
  logic [2:0] done_rd;
  logic [7:0] done_data;
  logic [7:0] flags_reg;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequenciador #(.DATA_W(8), .NUM_REGS(8), .REG_AW(3)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operacao(alu_operacao),
    .alu_resultado(alu_resultado), .alu_flags(alu_flags),
    .done(done), .done_rd(done_rd), .done_data(done_data),
    .flags_reg(flags_reg), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  logic [8:0] s_sum;
  logic [7:0] s_r;
  logic       s_c, s_v;
  always_comb begin
    s_sum = {1'b0, alu_a} + {1'b0, alu_b};
    s_r   = alu_a ^ alu_b;
    s_c   = s_sum[8];
    s_v   = 1'b0;
    case (alu_operacao)
      4'h0: begin
        s_r = s_sum[7:0];
        s_v = (alu_a[7] == alu_b[7]) && (s_r[7] != alu_a[7]);
      end
      4'h1: begin
        s_r = alu_a - alu_b;
        s_c = (alu_a < alu_b);
      end
      4'h2: s_r = alu_a & alu_b;
      4'h9: s_r = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      default: ;
    endcase
    alu_resultado = s_r;
    alu_flags = {s_r[7], (s_r == 8'h00), s_c, (!s_r[7] && s_r != 8'h00), 1'b0, 1'b0, s_v, 1'b0};
  end

  // Drives one instruction from IDLE and waits (bounded) for its retirement.
  // Returns at the falling edge where done is high; lat = edges after accept
  // (-1 on timeout), busy_rdy = samples with instr_ready high while busy.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic ie, input logic [7:0] im,
                       output int lat, output int busy_rdy);
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
    instr_imm_en = ie; instr_imm = im; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = -1;
    busy_rdy = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) begin lat = n; break; end
      if (instr_ready) busy_rdy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr_op = 4'h0; instr_rd = 3'd0; instr_rs = 3'd0;
    instr_rt = 3'd0; instr_imm_en = 1'b0; instr_imm = 8'h00; dbg_addr = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got %b exp 0", instr_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_idle got %b exp 1", instr_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (flags_reg !== 8'h00) begin errors++; $display("FAIL rst_flags got %h exp 00", flags_reg); end
    checks++; if ({alu_a, alu_b, alu_operacao} !== 20'h0) begin errors++; $display("FAIL rst_alu_regs got %h %h %h exp 0", alu_a, alu_b, alu_operacao); end
    checks++; if ({done_rd, done_data} !== 11'h0) begin errors++; $display("FAIL rst_done_fields got %h %h exp 0", done_rd, done_data); end
    checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL rst_r3 got %h exp 00", dbg_data); end
  endtask

  task automatic test_first_add();
    int lat, br;
    dbg_addr = 3'd1;
    issue(4'h0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hC8, lat, br);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add1_latency got %0d exp 3", lat); end
    checks++; if (br !== 0) begin errors++; $display("FAIL add1_ready_busy got %0d exp 0", br); end
    checks++; if (done_rd !== 3'd1) begin errors++; $display("FAIL add1_done_rd got %0d exp 1", done_rd); end
    checks++; if (done_data !== 8'hC8) begin errors++; $display("FAIL add1_done_data got %h exp c8", done_data); end
    checks++; if (dbg_data !== 8'hC8) begin errors++; $display("FAIL add1_r1 got %h exp c8", dbg_data); end
    checks++; if (flags_reg !== 8'h80) begin errors++; $display("FAIL add1_flags got %h exp 80", flags_reg); end
    checks++; if ({alu_a, alu_b, alu_operacao} !== {8'h00, 8'hC8, 4'h0}) begin errors++; $display("FAIL add1_alu_in got %h %h %h exp 00 c8 0", alu_a, alu_b, alu_operacao); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add1_done_pulse got %b exp 0", done); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL add1_ready_after got %b exp 1", instr_ready); end
  endtask

  task automatic test_carry_flags();
    int lat, br;
    dbg_addr = 3'd2;
    issue(4'h0, 3'd2, 3'd1, 3'd0, 1'b1, 8'h64, lat, br);
    checks++; if (done_data !== 8'h2C) begin errors++; $display("FAIL carry_data got %h exp 2c", done_data); end
    checks++; if (dbg_data !== 8'h2C) begin errors++; $display("FAIL carry_r2 got %h exp 2c", dbg_data); end
    checks++; if (flags_reg !== 8'h30) begin errors++; $display("FAIL carry_flags got %h exp 30", flags_reg); end
    @(negedge clk);
    dbg_addr = 3'd7;
    issue(4'h0, 3'd7, 3'd1, 3'd2, 1'b0, 8'h55, lat, br);
    checks++; if (alu_b !== 8'h2C) begin errors++; $display("FAIL rt_operand got %h exp 2c", alu_b); end
    checks++; if (dbg_data !== 8'hF4) begin errors++; $display("FAIL rt_r7 got %h exp f4", dbg_data); end
    checks++; if (flags_reg !== 8'h80) begin errors++; $display("FAIL rt_flags got %h exp 80", flags_reg); end
    @(negedge clk);
    dbg_addr = 3'd6;
    issue(4'h3, 3'd6, 3'd1, 3'd0, 1'b1, 8'h64, lat, br);
    checks++; if (dbg_data !== 8'hAC) begin errors++; $display("FAIL xor_r6 got %h exp ac", dbg_data); end
    checks++; if (flags_reg !== 8'h80) begin errors++; $display("FAIL xor_carry_masked got %h exp 80", flags_reg); end
    @(negedge clk);
    dbg_addr = 3'd3;
    issue(4'h2, 3'd3, 3'd2, 3'd0, 1'b1, 8'h00, lat, br);
    checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL and_r3 got %h exp 00", dbg_data); end
    checks++; if (flags_reg !== 8'h40) begin errors++; $display("FAIL and_flags got %h exp 40", flags_reg); end
    @(negedge clk);
  endtask

  task automatic test_div_nop();
    int lat, br;
    dbg_addr = 3'd5;
    issue(4'hE, 3'd5, 3'd1, 3'd0, 1'b1, 8'h38, lat, br);
    checks++; if (done_data !== 8'h00) begin errors++; $display("FAIL nop1_data got %h exp 00", done_data); end
    checks++; if (done_rd !== 3'd5) begin errors++; $display("FAIL nop1_rd got %0d exp 5", done_rd); end
    checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL nop1_r5 got %h exp 00", dbg_data); end
    checks++; if (flags_reg !== 8'h40) begin errors++; $display("FAIL nop1_flags got %h exp 40", flags_reg); end
    @(negedge clk);
    dbg_addr = 3'd4;
    issue(4'h9, 3'd4, 3'd1, 3'd0, 1'b1, 8'h00, lat, br);
    checks++; if (done_data !== 8'hFF) begin errors++; $display("FAIL div0_data got %h exp ff", done_data); end
    checks++; if (dbg_data !== 8'hFF) begin errors++; $display("FAIL div0_r4 got %h exp ff", dbg_data); end
    checks++; if (flags_reg !== 8'h80) begin errors++; $display("FAIL div0_flags got %h exp 80", flags_reg); end
    @(negedge clk);
    dbg_addr = 3'd1;
    issue(4'hE, 3'd1, 3'd1, 3'd0, 1'b1, 8'h01, lat, br);
    checks++; if (done !== 1'b1 || done_data !== 8'h00) begin errors++; $display("FAIL nop2_done got %b %h exp 1 00", done, done_data); end
    checks++; if (dbg_data !== 8'hC8) begin errors++; $display("FAIL nop2_r1 got %h exp c8", dbg_data); end
    checks++; if (flags_reg !== 8'h80) begin errors++; $display("FAIL nop2_flags got %h exp 80", flags_reg); end
    @(negedge clk);
  endtask

  task automatic test_r0_back_to_back();
    int lat, br, cnt, first, last, gap_bad;
    dbg_addr = 3'd0;
    issue(4'h0, 3'd0, 3'd1, 3'd0, 1'b1, 8'h01, lat, br);
    checks++; if (done_data !== 8'hC9) begin errors++; $display("FAIL r0_done_data got %h exp c9", done_data); end
    checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL r0_read got %h exp 00", dbg_data); end
    @(negedge clk);
    // Valid held high: each retirement increments R1.
    dbg_addr = 3'd1;
    instr_op = 4'h0; instr_rd = 3'd1; instr_rs = 3'd1; instr_rt = 3'd0;
    instr_imm_en = 1'b1; instr_imm = 8'h01; instr_valid = 1'b1;
    cnt = 0; first = -1; last = -1; gap_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (first < 0) first = i;
        else if (i - last != 4) gap_bad++;
        last = i;
        cnt++;
      end
    end
    instr_valid = 1'b0;
    checks++; if (cnt !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", cnt); end
    checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first got %0d exp 3", first); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_spacing got %0d bad exp 0", gap_bad); end
    checks++; if (done_data !== 8'hCC) begin errors++; $display("FAIL b2b_last_data got %h exp cc", done_data); end
    checks++; if (dbg_data !== 8'hCC) begin errors++; $display("FAIL b2b_r1 got %h exp cc", dbg_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    dbg_addr = 3'd5;
    instr_op = 4'h0; instr_rd = 3'd5; instr_rs = 3'd1; instr_rt = 3'd0;
    instr_imm_en = 1'b1; instr_imm = 8'h11; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    #1;
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", instr_ready); end
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL midrst_done got %0d pulses exp 0", done_seen); end
    checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL midrst_r5 got %h exp 00", dbg_data); end
    checks++; if (flags_reg !== 8'h00) begin errors++; $display("FAIL midrst_flags got %h exp 00", flags_reg); end
    dbg_addr = 3'd1;
    #1;
    checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL midrst_r1 got %h exp 00", dbg_data); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_idle got %b exp 1", instr_ready); end
  endtask

  initial begin
    test_reset();
    test_first_add();
    test_carry_flags();
    test_div_nop();
    test_r0_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
